// File: rtl/rate_synchronizer_mc.sv
// Multi-channel rate synchronizer: on each synchronized MCU rate edge, pops one
// interleaved frame from an FWFT FIFO and publishes it, or applies an underrun policy.
module rate_synchronizer_mc #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FCNT_W      = 6,
    parameter int unsigned UCNT_W      = 16
) (
    input  logic                         clk_12mhz,
    input  logic                         rst_n,
    input  logic                         mcu_rate_clk,
    input  logic [DATA_W-1:0]            fifo_data,
    input  logic                         fifo_empty,
    input  logic [FCNT_W-1:0]            fifo_count,
    output logic                         fifo_read_en,
    input  logic [1:0]                   underrun_mode,
    output logic [CHANNELS*DATA_W-1:0]   audio_out,
    output logic                         sample_valid,
    output logic                         underrun,
    output logic                         edge_drop,
    output logic [UCNT_W-1:0]            underrun_count
);

    localparam int unsigned FRAME_W = CHANNELS * DATA_W;
    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, READ, PUBLISH} state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 sync_last_q;
    logic                 pending_q, pending_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic                 urun_flag_q, urun_flag_d;
    logic [FRAME_W-1:0]   shadow_q, shadow_d;
    logic [FRAME_W-1:0]   audio_q, audio_d;
    logic                 read_en_q, read_en_d;
    logic                 valid_q, valid_d;
    logic                 urun_q, urun_d;
    logic                 drop_q, drop_d;
    logic [UCNT_W-1:0]    ucnt_q, ucnt_d;

    logic                 edge_c;
    logic                 trigger_c;
    logic                 frame_ok_c;

    assign edge_c     = sync_q[SYNC_STAGES-1] & ~sync_last_q;
    assign trigger_c  = edge_c | pending_q;
    assign frame_ok_c = (fifo_count >= FCNT_W'(CHANNELS)) && !fifo_empty;

    // State register
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a short frame never starts a read so channels stay aligned
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (trigger_c) state_d = frame_ok_c ? READ : PUBLISH;
            READ:    if (ch_q == CH_W'(CHANNELS - 1)) state_d = PUBLISH;
            PUBLISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        pending_d   = pending_q;
        ch_d        = ch_q;
        urun_flag_d = urun_flag_q;
        shadow_d    = shadow_q;
        audio_d     = audio_q;
        ucnt_d      = ucnt_q;
        valid_d     = 1'b0;
        urun_d      = 1'b0;
        drop_d      = edge_c & pending_q;
        read_en_d   = (state_d == READ);

        // One-deep edge memory: held while busy, consumed when IDLE is left
        if (edge_c && pending_q) begin
            pending_d = 1'b1;
        end else if (edge_c && state_q != IDLE) begin
            pending_d = 1'b1;
        end else if (state_q == IDLE && state_d != IDLE) begin
            pending_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (trigger_c) begin
                    ch_d        = '0;
                    urun_flag_d = !frame_ok_c;
                end
            end
            READ: begin
                shadow_d[ch_q*DATA_W +: DATA_W] = fifo_data;
                ch_d = ch_q + CH_W'(1);
            end
            PUBLISH: begin
                valid_d = 1'b1;
                urun_d  = urun_flag_q;
                if (urun_flag_q) begin
                    if (ucnt_q != {UCNT_W{1'b1}}) ucnt_d = ucnt_q + UCNT_W'(1);
                    for (int unsigned c = 0; c < CHANNELS; c++) begin
                        case (underrun_mode)
                            2'b01:   audio_d[c*DATA_W +: DATA_W] = '0;
                            2'b10:   audio_d[c*DATA_W +: DATA_W] =
                                         DATA_W'($signed(audio_q[c*DATA_W +: DATA_W]) >>> 1);
                            default: audio_d[c*DATA_W +: DATA_W] = audio_q[c*DATA_W +: DATA_W];
                        endcase
                    end
                end else begin
                    audio_d = shadow_q;
                end
            end
            default: ;
        endcase
    end

    // Synchronizer and datapath registers
    always_ff @(posedge clk_12mhz or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            sync_last_q <= 1'b0;
            pending_q   <= 1'b0;
            ch_q        <= '0;
            urun_flag_q <= 1'b0;
            shadow_q    <= '0;
            audio_q     <= '0;
            read_en_q   <= 1'b0;
            valid_q     <= 1'b0;
            urun_q      <= 1'b0;
            drop_q      <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], mcu_rate_clk};
            sync_last_q <= sync_q[SYNC_STAGES-1];
            pending_q   <= pending_d;
            ch_q        <= ch_d;
            urun_flag_q <= urun_flag_d;
            shadow_q    <= shadow_d;
            audio_q     <= audio_d;
            read_en_q   <= read_en_d;
            valid_q     <= valid_d;
            urun_q      <= urun_d;
            drop_q      <= drop_d;
            ucnt_q      <= ucnt_d;
        end
    end

    assign fifo_read_en   = read_en_q;
    assign audio_out      = audio_q;
    assign sample_valid   = valid_q;
    assign underrun       = urun_q;
    assign edge_drop      = drop_q;
    assign underrun_count = ucnt_q;

endmodule

// File: tb/tb_rate_synchronizer_mc.sv
// Bench for rate_synchronizer_mc: queue-based FWFT FIFO, frame-level reference
// model, directed boundary cases plus a randomized 48 kHz / 62.5 kHz rate run.
module tb_rate_synchronizer_mc;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned CHANNELS    = 2;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FCNT_W      = 6;
    localparam int unsigned UCNT_W      = 16;
    localparam int unsigned FRAME_W     = CHANNELS * DATA_W;

    logic                  clk_12mhz;
    logic                  rst_n;
    logic                  mcu_rate_clk;
    logic [DATA_W-1:0]     fifo_data;
    logic                  fifo_empty;
    logic [FCNT_W-1:0]     fifo_count;
    logic                  fifo_read_en;
    logic [1:0]            underrun_mode;
    logic [FRAME_W-1:0]    audio_out;
    logic                  sample_valid;
    logic                  underrun;
    logic                  edge_drop;
    logic [UCNT_W-1:0]     underrun_count;

    rate_synchronizer_mc #(
        .DATA_W(DATA_W), .CHANNELS(CHANNELS), .SYNC_STAGES(SYNC_STAGES),
        .FCNT_W(FCNT_W), .UCNT_W(UCNT_W)
    ) dut (
        .clk_12mhz(clk_12mhz), .rst_n(rst_n), .mcu_rate_clk(mcu_rate_clk),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .fifo_read_en(fifo_read_en), .underrun_mode(underrun_mode),
        .audio_out(audio_out), .sample_valid(sample_valid), .underrun(underrun),
        .edge_drop(edge_drop), .underrun_count(underrun_count)
    );

    initial clk_12mhz = 1'b0;
    always #42 clk_12mhz = ~clk_12mhz;

    typedef struct {
        logic [FRAME_W-1:0] f;
        bit                 ur;
        int unsigned        cnt;
    } exp_t;

    int             n_chk = 0;
    int             n_err = 0;
    int             drops = 0;
    bit             mon_en = 0;
    logic [DATA_W-1:0] fifo_m[$];
    logic [DATA_W-1:0] ref_q[$];
    exp_t           exp_q[$];
    logic [FRAME_W-1:0] m_out = '0;
    int unsigned    m_ucnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void fifo_drive();
        fifo_count = FCNT_W'(fifo_m.size());
        fifo_empty = (fifo_m.size() == 0);
        fifo_data  = (fifo_m.size() > 0) ? fifo_m[0] : '0;
    endfunction

    function automatic void fifo_write(input logic [DATA_W-1:0] w);
        fifo_m.push_back(w);
        ref_q.push_back(w);
        fifo_drive();
    endfunction

    // Frame-level reference: a full frame is consumed, otherwise the policy is applied
    function automatic exp_t model_edge();
        exp_t e;
        if (ref_q.size() >= CHANNELS) begin
            for (int c = 0; c < int'(CHANNELS); c++) m_out[c*DATA_W +: DATA_W] = ref_q.pop_front();
            e.ur = 0;
        end else begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                int s;
                s = int'($signed(m_out[c*DATA_W +: DATA_W]));
                if (underrun_mode == 2'b01) s = 0;
                else if (underrun_mode == 2'b10) s = (s < 0) ? -((-s + 1) / 2) : s / 2;
                m_out[c*DATA_W +: DATA_W] = DATA_W'(s);
            end
            if (m_ucnt != (2**UCNT_W) - 1) m_ucnt++;
            e.ur = 1;
        end
        e.f   = m_out;
        e.cnt = m_ucnt;
        return e;
    endfunction

    // One clock: pop on the edge if read_en was high, then sample at posedge+1
    task automatic tick();
        logic pop;
        @(negedge clk_12mhz);
        pop = fifo_read_en;
        @(posedge clk_12mhz);
        #1;
        if (pop && fifo_m.size() > 0) void'(fifo_m.pop_front());
        fifo_drive();
        if (edge_drop) drops++;
        if (mon_en && sample_valid) begin
            if (exp_q.size() == 0) begin
                check("rate_unexpected_valid", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rate_audio", 64'(audio_out), 64'(e.f));
                check("rate_underrun", 64'(underrun), 64'(e.ur));
                check("rate_ucnt", 64'(underrun_count), 64'(e.cnt));
            end
        end
    endtask

    task automatic run_edge(input string tag);
        exp_t e;
        int lat;
        int reads;
        bit got;
        e = model_edge();
        mcu_rate_clk = 1'b1;
        lat = 0; reads = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            lat++;
            if (fifo_read_en) reads++;
            if (sample_valid) got = 1;
        end
        check({tag, "_valid"}, 64'(got), 64'(1));
        check({tag, "_lat"}, 64'(lat), e.ur ? 64'(SYNC_STAGES + 2) : 64'(SYNC_STAGES + 2 + CHANNELS));
        check({tag, "_reads"}, 64'(reads), e.ur ? 64'(0) : 64'(CHANNELS));
        check({tag, "_audio"}, 64'(audio_out), 64'(e.f));
        check({tag, "_underrun"}, 64'(underrun), 64'(e.ur));
        check({tag, "_ucnt"}, 64'(underrun_count), 64'(e.cnt));
        mcu_rate_clk = 1'b0;
        tick();
        check({tag, "_pulse"}, 64'(sample_valid), 64'(0));
        repeat (SYNC_STAGES + 2) tick();
    endtask

    initial begin
        rst_n = 1'b0; mcu_rate_clk = 1'b0; underrun_mode = 2'b00;
        fifo_drive();
        repeat (3) tick();
        check("rst_audio", 64'(audio_out), 64'(0));
        check("rst_valid", 64'(sample_valid), 64'(0));
        check("rst_read_en", 64'(fifo_read_en), 64'(0));
        check("rst_ucnt", 64'(underrun_count), 64'(0));
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic frame
        fifo_write(16'h0001); fifo_write(16'h0002);
        run_edge("t1");
        check("t1_const", 64'(audio_out), 64'(32'h0002_0001));

        // Hold underrun on empty FIFO
        run_edge("t2_hold");

        // Decay then zero
        fifo_write(16'h8000); fifo_write(16'h0100);
        run_edge("t3_load");
        underrun_mode = 2'b10;
        repeat (3) run_edge("t3_decay");
        check("t3_decay_const", 64'(audio_out), 64'(32'h0020_F000));
        underrun_mode = 2'b01;
        run_edge("t3_zero");

        // Partial frame must not be consumed
        underrun_mode = 2'b00;
        fifo_write(16'($urandom));
        run_edge("t4_partial");
        check("t4_count_kept", 64'(fifo_count), 64'(1));
        fifo_write(16'($urandom));
        run_edge("t4_aligned");

        // Randomized frames and modes
        for (int k = 0; k < 8; k++) begin
            int nfr;
            underrun_mode = 2'($urandom_range(0, 3));
            nfr = int'($urandom_range(0, 2));
            for (int f = 0; f < nfr * int'(CHANNELS); f++) fifo_write(16'($urandom));
            run_edge("t5_rand");
        end

        // 48 kHz frame writes against 62.5 kHz rate edges
        begin
            int next_wr;
            int last_edge;
            int n_ur_model;
            int ucnt_start;
            int ucnt_before;
            underrun_mode = 2'($urandom_range(0, 3));
            next_wr = 37; last_edge = -1000; n_ur_model = 0;
            ucnt_start = int'(underrun_count);
            mon_en = 1;
            for (int t = 0; t < 4800; t++) begin
                if (t >= next_wr && !(t - last_edge >= 1 && t - last_edge <= 8)) begin
                    for (int c = 0; c < int'(CHANNELS); c++) fifo_write(16'($urandom));
                    next_wr += 250;
                end
                if (t % 192 == 0) begin
                    exp_t e;
                    ucnt_before = int'(m_ucnt);
                    e = model_edge();
                    if (e.ur) n_ur_model++;
                    exp_q.push_back(e);
                    mcu_rate_clk = 1'b1;
                    last_edge = t;
                end
                if (t % 192 == 96) mcu_rate_clk = 1'b0;
                tick();
            end
            repeat (20) tick();
            mon_en = 0;
            check("rate_all_published", 64'(exp_q.size()), 64'(0));
            check("rate_ucnt_delta", 64'(int'(underrun_count) - ucnt_start), 64'(n_ur_model));
            check("rate_words_left", 64'(fifo_m.size()), 64'(ref_q.size()));
        end

        // Reset during READ after one pop
        begin
            bit seen;
            underrun_mode = 2'b00;
            while (fifo_m.size() > 0) void'(fifo_m.pop_front());
            ref_q.delete();
            fifo_drive();
            fifo_write(16'h1234); fifo_write(16'h5678);
            mcu_rate_clk = 1'b1;
            seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                tick();
                if (fifo_read_en) seen = 1;
            end
            check("t7_read_seen", 64'(seen), 64'(1));
            tick();
            check("t7_one_pop", 64'(fifo_m.size()), 64'(1));
            rst_n = 1'b0;
            mcu_rate_clk = 1'b0;
            #1;
            check("t7_read_en", 64'(fifo_read_en), 64'(0));
            check("t7_audio", 64'(audio_out), 64'(0));
            check("t7_valid", 64'(sample_valid), 64'(0));
            check("t7_underrun", 64'(underrun), 64'(0));
            check("t7_drop", 64'(edge_drop), 64'(0));
            check("t7_ucnt", 64'(underrun_count), 64'(0));
            while (fifo_m.size() > 0) void'(fifo_m.pop_front());
            ref_q.delete();
            fifo_drive();
            m_out = '0; m_ucnt = 0;
            repeat (2) tick();
            rst_n = 1'b1;
            repeat (2) tick();
            fifo_write(16'($urandom)); fifo_write(16'($urandom));
            run_edge("t7_after");
        end

        check("edge_drop_never", 64'(drops), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
